// File: rtl/alu_arbiter.sv
// Two-port round-robin front end that shares one alu between two requesters.
// The op stage drives the alu; the response stage registers result, flags and source port.

module alu #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   f,
    output logic [N-1:0] y,
    output logic         zero,
    output logic         carry_out,
    output logic         overflow
);

    logic [N-1:0] bb;
    logic [N:0]   sum;
    logic         ov_raw;

    // f[2] selects ~b with carry-in, turning add into subtract
    always_comb begin
        bb     = f[2] ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, f[2]};
        ov_raw = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
        case (f[1:0])
            2'b00:   y = a & bb;
            2'b01:   y = a | bb;
            2'b10:   y = sum[N-1:0];
            default: y = {{(N-1){1'b0}}, sum[N-1] ^ ov_raw};
        endcase
        carry_out = f[1] & sum[N];
        overflow  = f[1] & ov_raw;
        zero      = (y == '0);
    end

endmodule

module alu_arbiter #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_f,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_f,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_src,
    output logic [N-1:0] rsp_y,
    output logic         rsp_zero,
    output logic         rsp_carry,
    output logic         rsp_overflow,
    output logic         busy
);

    logic         op_valid_q, op_valid_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic [2:0]   op_f_q, op_f_d;
    logic         op_src_q, op_src_d;
    logic         last_q, last_d;

    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_src_q, rsp_src_d;
    logic [N-1:0] rsp_y_q, rsp_y_d;
    logic         rsp_zero_q, rsp_zero_d;
    logic         rsp_carry_q, rsp_carry_d;
    logic         rsp_overflow_q, rsp_overflow_d;

    logic         rsp_advance, op_advance;
    logic         grant_valid, grant_idx;
    logic         acc0, acc1;

    logic [N-1:0] alu_y;
    logic         alu_zero, alu_carry, alu_overflow;

    alu #(.N(N)) u_alu (
        .a         (op_a_q),
        .b         (op_b_q),
        .f         (op_f_q),
        .y         (alu_y),
        .zero      (alu_zero),
        .carry_out (alu_carry),
        .overflow  (alu_overflow)
    );

    always_comb begin
        rsp_advance = !rsp_valid_q || rsp_ready;
        op_advance  = !op_valid_q || rsp_advance;
        grant_valid = req0_valid || req1_valid;
        // On a tie the port that did not win last time is served
        if (req0_valid && req1_valid) begin
            grant_idx = ~last_q;
        end else begin
            grant_idx = req1_valid;
        end
        req0_ready = rst_n && op_advance && grant_valid && !grant_idx;
        req1_ready = rst_n && op_advance && grant_valid && grant_idx;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
    end

    always_comb begin
        op_valid_d     = op_valid_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_f_d         = op_f_q;
        op_src_d       = op_src_q;
        last_d         = last_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_src_d      = rsp_src_q;
        rsp_y_d        = rsp_y_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;

        if (op_advance) begin
            op_valid_d = acc0 || acc1;
        end
        if (acc0) begin
            op_a_d   = req0_a;
            op_b_d   = req0_b;
            op_f_d   = req0_f;
            op_src_d = 1'b0;
            last_d   = 1'b0;
        end else if (acc1) begin
            op_a_d   = req1_a;
            op_b_d   = req1_b;
            op_f_d   = req1_f;
            op_src_d = 1'b1;
            last_d   = 1'b1;
        end

        if (rsp_advance) begin
            rsp_valid_d = op_valid_q;
            if (op_valid_q) begin
                rsp_src_d      = op_src_q;
                rsp_y_d        = alu_y;
                rsp_zero_d     = alu_zero;
                rsp_carry_d    = alu_carry;
                rsp_overflow_d = alu_overflow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q     <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_f_q         <= '0;
            op_src_q       <= 1'b0;
            last_q         <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_src_q      <= 1'b0;
            rsp_y_q        <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            op_valid_q     <= op_valid_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_f_q         <= op_f_d;
            op_src_q       <= op_src_d;
            last_q         <= last_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_src_q      <= rsp_src_d;
            rsp_y_q        <= rsp_y_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_src      = rsp_src_q;
    assign rsp_y        = rsp_y_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign busy         = op_valid_q || rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push expected responses,
// a separate monitor pops and compares whenever a response is taken.

module tb_alu_arbiter;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_f, req1_f;
    logic         rsp_valid, rsp_ready, rsp_src, rsp_zero, rsp_carry, rsp_overflow, busy;
    logic [N-1:0] rsp_y;

    typedef struct packed {
        logic       src;
        logic [7:0] y;
        logic       z;
        logic       c;
        logic       o;
    } rsp_t;

    rsp_t q[$];
    rsp_t exp0, exp1;
    logic acc_log[$];
    logic m_last, m_op_v, m_rsp_v;
    int   n_acc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N(N)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_f       (req0_f),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_f       (req1_f),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_src      (rsp_src),
        .rsp_y        (rsp_y),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference alu: integer arithmetic, signed range test for overflow
    function automatic rsp_t alu_ref(input logic src, input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] f);
        rsp_t       r;
        logic [7:0] bb;
        int         cin, su, ss;
        bb    = f[2] ? ~b : b;
        cin   = f[2] ? 1 : 0;
        su    = int'(a) + int'(bb) + cin;
        ss    = int'($signed(a)) + int'($signed(bb)) + cin;
        r.src = src;
        r.c   = 1'b0;
        r.o   = 1'b0;
        case (f[1:0])
            2'd0: r.y = a & bb;
            2'd1: r.y = a | bb;
            2'd2: r.y = su[7:0];
            default: r.y = (ss < 0) ? 8'd1 : 8'd0;
        endcase
        if (f[1]) begin
            r.c = (su > 255);
            r.o = (ss > 127) || (ss < -128);
        end
        r.z = (r.y == 8'd0);
        return r;
    endfunction

    // Acceptance side: checks handshake against a pipeline-occupancy model, pushes expectations
    always @(negedge clk) begin : acc_mon
        logic g_v, g_i, a0, a1, radv, oadv;
        if (!rst_n) begin
            m_last  = 1'b1;
            m_op_v  = 1'b0;
            m_rsp_v = 1'b0;
            q.delete();
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
        end else begin
            radv = !m_rsp_v || rsp_ready;
            oadv = !m_op_v || radv;
            g_v  = req0_valid || req1_valid;
            g_i  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
            check("ready0", req0_ready, oadv && g_v && !g_i);
            check("ready1", req1_ready, oadv && g_v && g_i);
            check("rsp_valid", rsp_valid, m_rsp_v);
            check("busy", busy, m_op_v || m_rsp_v);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0) begin
                q.push_back(exp0);
                acc_log.push_back(1'b0);
                m_last = 1'b0;
                n_acc++;
            end
            if (a1) begin
                q.push_back(exp1);
                acc_log.push_back(1'b1);
                m_last = 1'b1;
                n_acc++;
            end
            m_rsp_v = radv ? m_op_v : m_rsp_v;
            m_op_v  = oadv ? (a0 || a1) : m_op_v;
        end
    end

    rsp_t held;
    logic prev_stall = 1'b0;

    always @(negedge clk) begin : rsp_mon
        rsp_t got, e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (rsp_valid) begin
            got = {rsp_src, rsp_y, rsp_zero, rsp_carry, rsp_overflow};
            if (prev_stall) check("rsp_stable", got, held);
            if (rsp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected actual=%0h required=none", got);
                end else begin
                    e = q.pop_front();
                    check("rsp_data", got, e);
                end
            end
            prev_stall = !rsp_ready;
            held       = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        int   k, stall_acc, start, cnt;
        logic a0, a1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_f = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_f = 0;
        rsp_ready  = 1;
        exp0 = '0;
        exp1 = '0;
        #2;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_rsp", {rsp_src, rsp_y, rsp_zero, rsp_carry, rsp_overflow}, 0);
        repeat (2) cyc();
        rst_n = 1;
        cyc();

        // Single add on port 0, latency two cycles
        req0_a = 8'h02; req0_b = 8'h03; req0_f = 3'b010;
        exp0 = '{1'b0, 8'h05, 1'b0, 1'b0, 1'b0};
        req0_valid = 1;
        @(negedge clk);
        check("add_ready", req0_ready, 1);
        cyc();
        req0_valid = 0;
        @(negedge clk);
        check("add_lat1_valid", rsp_valid, 0);
        @(negedge clk);
        check("add_lat2_valid", rsp_valid, 1);
        check("add_y", rsp_y, 8'h05);
        check("add_zero", rsp_zero, 0);
        check("add_src", rsp_src, 0);
        cyc();

        // Single OR on port 1 leaves last=1 so the next tie goes to port 0
        req1_a = 8'h0F; req1_b = 8'hF0; req1_f = 3'b001;
        exp1 = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        req1_valid = 1;
        @(negedge clk);
        check("or_ready", req1_ready, 1);
        cyc();
        req1_valid = 0;
        repeat (3) cyc();

        // Contention for 6 cycles
        acc_log.delete();
        req0_a = 8'h7F; req0_b = 8'h01; req0_f = 3'b010;
        exp0 = '{1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        req1_a = 8'h05; req1_b = 8'h05; req1_f = 3'b110;
        exp1 = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        req0_valid = 1;
        req1_valid = 1;
        repeat (6) cyc();
        req0_valid = 0;
        req1_valid = 0;
        check("cont_count", acc_log.size(), 6);
        for (int i = 0; i < acc_log.size() && i < 6; i++) begin
            check("cont_grant", acc_log[i], i % 2);
        end
        repeat (4) cyc();
        check("cont_drained", q.size(), 0);

        // Backpressure: 4 stalled cycles, port 1 streaming distinct payloads
        rsp_ready = 0;
        k = 0;
        stall_acc = 0;
        req1_a = 8'h10; req1_b = 8'h01; req1_f = 3'b010;
        exp1 = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        req1_valid = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req1_ready) begin
                if (c < 4) stall_acc++;
                k++;
            end
            cyc();
            if (c == 3) rsp_ready = 1;
            req1_a = 8'(8'h10 + k);
            exp1   = '{1'b1, 8'(8'h11 + k), 1'b0, 1'b0, 1'b0};
        end
        req1_valid = 0;
        rsp_ready  = 1;
        check("bp_stall_accepts", stall_acc, 2);
        repeat (5) cyc();
        check("bp_drained", q.size(), 0);

        // Random soak
        start = n_acc;
        cnt   = 0;
        while ((n_acc - start) < 1000 && cnt < 20000) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            cyc();
            cnt++;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_a = 8'($urandom);
                req0_b = 8'($urandom);
                req0_f = 3'($urandom);
                exp0   = alu_ref(1'b0, req0_a, req0_b, req0_f);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_a = 8'($urandom);
                req1_b = 8'($urandom);
                req1_f = 3'($urandom);
                exp1   = alu_ref(1'b1, req1_a, req1_b, req1_f);
            end
        end
        @(negedge clk);
        cyc();
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        check("soak_count", (n_acc - start) >= 1000, 1);
        cnt = 0;
        while ((q.size() != 0 || busy) && cnt < 50) begin
            cyc();
            cnt++;
        end
        check("soak_drained", q.size(), 0);

        // Reset with both stages full
        rsp_ready = 0;
        req0_a = 8'h33; req0_b = 8'h11; req0_f = 3'b110;
        exp0 = alu_ref(1'b0, req0_a, req0_b, req0_f);
        req1_a = 8'h81; req1_b = 8'h81; req1_f = 3'b010;
        exp1 = alu_ref(1'b1, req1_a, req1_b, req1_f);
        req0_valid = 1;
        req1_valid = 1;
        repeat (3) cyc();
        check("prerst_busy", busy, 1);
        check("prerst_rsp_valid", rsp_valid, 1);
        rst_n = 0;
        #1;
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready0", req0_ready, 0);
        check("midrst_ready1", req1_ready, 0);
        repeat (2) cyc();
        acc_log.delete();
        rsp_ready = 1;
        rst_n = 1;
        @(negedge clk);
        check("postrst_tie_ready0", req0_ready, 1);
        check("postrst_tie_ready1", req1_ready, 0);
        cyc();
        req0_valid = 0;
        req1_valid = 0;
        check("postrst_first_src", (acc_log.size() > 0) ? 32'(acc_log[0]) : 32'hDEAD, 0);
        repeat (5) cyc();
        check("final_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares a single `alu` instance between two independent requesters. Each requester issues `{a, b, f}` operations over a valid/ready handshake. The block returns a registered result and flags, tagged with the source port, over a single valid/ready response channel. It sits between the ALU datapath and its clients, such as a sequencer and a debug/test port, so that only one ALU is instantiated per width.

## Interface
Parameters:
- `N`, default 8: operand/result width, passed to the internal `alu #(N)`.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req0_valid`, in, 1: port 0 has an operation pending.
- `req0_ready`, out, 1: port 0 operation accepted this cycle when high together with `req0_valid`.
- `req0_a`, in, N: port 0 operand a.
- `req0_b`, in, N: port 0 operand b.
- `req0_f`, in, 3: port 0 ALU function code, passed unmodified to `alu.f`.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_f`: same as port 0, for port 1.
- `rsp_valid`, out, 1: response register holds a result.
- `rsp_ready`, in, 1: consumer takes the response this cycle.
- `rsp_src`, out, 1: port index that issued the response.
- `rsp_y`, out, N: ALU result.
- `rsp_zero`, out, 1: ALU `zero` flag.
- `rsp_carry`, out, 1: ALU `carry_out` flag.
- `rsp_overflow`, out, 1: ALU `overflow` flag.
- `busy`, out, 1: high when the op stage or the response stage holds a valid entry.

## Operation
- Two-stage pipeline:
  - Op stage: `op_valid`, `op_a`, `op_b`, `op_f`, `op_src`. The internal ALU is driven combinationally from the op stage only.
  - Response stage: `rsp_*`.
- `rsp_advance = !rsp_valid || rsp_ready`.
- `op_advance = !op_valid || rsp_advance`.
- Op stage moves into the response stage when `op_valid && rsp_advance`. The response stage captures ALU y, zero, carry_out, overflow and `op_src`.
- Arbitration pointer `last` (1 bit) records the most recently accepted port.
- Grant rules, evaluated every cycle:
  - If only one port is valid, that port is granted.
  - If both ports are valid, the port != `last` is granted.
  - If neither port is valid, nothing is granted.
- `reqX_ready = op_advance && grant==X`. At most one ready is high per cycle. The ungranted port always sees ready=0.
- On an accepted transfer (`reqX_valid && reqX_ready`):
  - Operands load into the op stage and `op_src=X`.
  - `last` becomes X.
- `last` does not change when no transfer occurs.
- Requester rules:
  - Hold valid and payload stable until accepted.
  - Dropping valid before acceptance is illegal and the result is unspecified.
- Response stage holds all `rsp_*` values stable while `rsp_valid && !rsp_ready`.
- Function codes are not decoded here. Result and flag semantics are owned by `alu`.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `op_valid=0`, `rsp_valid=0`.
  - `rsp_y=0`, `rsp_zero=0`, `rsp_carry=0`, `rsp_overflow=0`, `rsp_src=0`.
  - `last=1`, so port 0 wins the first tie.
  - `busy=0`, both readies 0 while in reset.
- Reset mid-operation: in-flight entries are discarded and no response is produced for them.
- Latency: request accepted in cycle t → `rsp_valid`=1 in cycle t+2.
- Throughput: one operation per cycle with `rsp_ready` held high. Under contention, ports alternate every cycle.
- Backpressure:
  - With `rsp_ready`=0 and both stages full, both readies are 0.
  - In the cycle `rsp_ready` returns to 1, readies re-enable combinationally. No bubble is inserted.
- Simultaneous events:
  - Response handshake, op-stage move and new accept can occur in the same cycle. All three take effect at the same edge.
- Combinational paths: `reqX_valid` → `reqY_ready`, and `rsp_ready` → `reqX_ready`. There is no combinational path from request inputs to `rsp_*`.

## Test plan
- Reset behaviour: assert `rst_n`=0 mid-stream with both stages full.
  - Required: `rsp_valid`=0 and `busy`=0 immediately, without waiting for a clock edge.
  - Required: after release, the first tie grants port 0.
- Single-port add: port 0 issues a=8'h02, b=8'h03, f=3'b010 (add) in cycle 0, `rsp_ready`=1.
  - Required in cycle 2: `rsp_valid`=1, y=8'h05, zero=0, `rsp_src`=0.
- Contention: both ports hold valid continuously for 6 cycles.
  - Port 0: a=8'h7F, b=8'h01, f=add.
  - Port 1: a=8'h05, b=8'h05, f=3'b110 (sub).
  - Required: grants alternate 0,1,0,1,0,1.
  - Required port 0 responses: y=8'h80, overflow=1.
  - Required port 1 responses: y=8'h00, zero=1.
- Backpressure: hold `rsp_ready`=0 for 4 cycles with port 1 streaming.
  - Required: exactly 2 ops accepted, and `rsp_*` stable across the stall.
  - Required: on release, the responses drain in order with no loss or duplication.
- Random soak: 1000 random ops on both ports with random valid and `rsp_ready`.
  - Required: every accepted op yields exactly one response, and responses appear in acceptance order.
  - Required: y and flags match a reference model of `alu` for every response.
